// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter slice.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Clock cycles from the accepting edge to the edge where ready returns high.
  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned parity_en,
                                            input int unsigned clks_per_bit);
    return (data_w + 2 + ((parity_en != 0) ? 1 : 0)) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period down-counter; tick marks the last cycle of each bit period.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (restart || tick) cnt_d = RELOAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_tx.sv
// LSB-first serialiser: start bit, DATA_W payload bits, optional even parity, stop bit.
module serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              done
);

  import serial_pkg::*;

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              accept;
  logic              tick;

  assign accept = load && ready_q;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= IDLE_LEVEL;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shreg_d = data_in;
          par_d   = ^data_in;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line changes on the same edge as the state.
  always_comb begin
    tx_d    = IDLE_LEVEL;
    ready_d = 1'b0;
    unique case (state_d)
      IDLE: begin
        tx_d    = IDLE_LEVEL;
        ready_d = 1'b1;
      end
      START:   tx_d = START_BIT;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = STOP_BIT;
      default: tx_d = IDLE_LEVEL;
    endcase
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule
